// File: rtl/spike_result_acc.sv
// Spiking-convolution result accumulator: per-neuron residue over NUM_TS timesteps, row-major readout.
// Optional reference-spike compare when SPIKE_RESULT_ACC_REFCHK_EN is defined.
//
// state | meaning
// ACCUM | accepting partial-sum packets until DEPTH_R**2 are kept
// READ  | streaming the spike/residue map, one entry per handshake
module spike_result_acc #(
  parameter int WIDTH_PKT  = 32,
  parameter int WIDTH_DATA = 13,
  parameter int ROW_LSB    = 16,
  parameter int ROW_W      = 5,
  parameter int DEPTH_R    = 21,
  parameter int THRE       = 64,
  parameter int NUM_TS     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH_PKT-1:0]    in_pkt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_spike,
  output logic [WIDTH_DATA-1:0]   out_residue,
  output logic [ROW_W-1:0]        out_row,
  output logic [ROW_W-1:0]        out_col,
  output logic [$clog2(NUM_TS):0] out_ts,
  output logic                    frame_done,
  output logic                    err_row
`ifdef SPIKE_RESULT_ACC_REFCHK_EN
  ,
  input  logic                    ref_spike,
  output logic [15:0]             mismatch_cnt
`endif
);

  localparam int IW   = (DEPTH_R > 1) ? $clog2(DEPTH_R) : 1;
  localparam int CW   = $clog2(DEPTH_R + 1);
  localparam int NPIX = DEPTH_R * DEPTH_R;
  localparam int PW   = $clog2(NPIX + 1);
  localparam int TSW  = $clog2(NUM_TS) + 1;
  localparam int SW   = WIDTH_DATA + 1;

  typedef enum logic {ACCUM, READ} state_t;

  state_t state_q, state_d;

  logic [WIDTH_DATA-1:0] residue_mem [DEPTH_R][DEPTH_R];
  logic                  spike_mem   [DEPTH_R][DEPTH_R];

  logic [CW-1:0]  col_cnt [DEPTH_R];
  logic [PW-1:0]  pkt_cnt;
  logic [IW-1:0]  rd_row, rd_col;
  logic [TSW-1:0] ts;

  logic [ROW_W-1:0]      r_in;
  logic [WIDTH_DATA-1:0] d_in;
  logic                  row_ok, keep, acc_fire, last_pkt, rd_fire, rd_last;
  logic [IW-1:0]         r_idx, c_idx;
  logic [CW-1:0]         col_cur;
  logic [SW-1:0]         base, sum, res_full;
  logic [WIDTH_DATA-1:0] res_sat;
  logic                  fire;
  logic                  unused_pkt;

  assign unused_pkt = ^in_pkt;

  assign r_in   = in_pkt[ROW_LSB +: ROW_W];
  assign d_in   = in_pkt[WIDTH_DATA-1:0];
  assign row_ok = int'(r_in) < DEPTH_R;
  // Out-of-range rows are steered to row 0 only to keep the lookup in bounds; keep is low for them.
  assign r_idx  = row_ok ? r_in[IW-1:0] : '0;
  assign col_cur = col_cnt[r_idx];
  assign c_idx  = col_cur[IW-1:0];
  assign keep   = row_ok && (int'(col_cur) < DEPTH_R);

  assign acc_fire = in_valid && (state_q == ACCUM);
  assign last_pkt = pkt_cnt == PW'(NPIX - 1);

  assign base     = (ts == '0) ? '0 : {1'b0, residue_mem[r_idx][c_idx]};
  assign sum      = base + {1'b0, d_in};
  assign fire     = sum > SW'(THRE);
  assign res_full = fire ? sum - SW'(THRE) : sum;
  assign res_sat  = res_full[WIDTH_DATA] ? '1 : res_full[WIDTH_DATA-1:0];

  assign rd_fire = out_valid && out_ready;
  assign rd_last = (rd_row == IW'(DEPTH_R - 1)) && (rd_col == IW'(DEPTH_R - 1));

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && keep && last_pkt) state_d = READ;
      end
      READ: begin
        if (rd_fire && rd_last) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ACCUM;
      pkt_cnt    <= '0;
      for (int i = 0; i < DEPTH_R; i++) col_cnt[i] <= '0;
      out_valid  <= 1'b0;
      rd_row     <= '0;
      rd_col     <= '0;
      ts         <= '0;
      frame_done <= 1'b0;
      err_row    <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_done <= 1'b0;
      if (acc_fire) begin
        if (!keep) begin
          err_row <= 1'b1;
        end else if (last_pkt) begin
          pkt_cnt <= '0;
          for (int i = 0; i < DEPTH_R; i++) col_cnt[i] <= '0;
        end else begin
          pkt_cnt        <= pkt_cnt + PW'(1);
          col_cnt[r_idx] <= col_cur + CW'(1);
        end
      end
      // The map is complete on the edge entering READ; out_valid follows one cycle later.
      if (state_q == READ) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
        end else if (out_ready) begin
          if (rd_last) begin
            out_valid <= 1'b0;
            rd_row    <= '0;
            rd_col    <= '0;
            if (ts == TSW'(NUM_TS - 1)) begin
              ts         <= '0;
              frame_done <= 1'b1;
            end else begin
              ts <= ts + TSW'(1);
            end
          end else if (rd_col == IW'(DEPTH_R - 1)) begin
            rd_col <= '0;
            rd_row <= rd_row + IW'(1);
          end else begin
            rd_col <= rd_col + IW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc_fire && keep) begin
      residue_mem[r_idx][c_idx] <= res_sat;
      spike_mem[r_idx][c_idx]   <= fire;
    end
  end

  assign out_spike   = out_valid & spike_mem[rd_row][rd_col];
  assign out_residue = out_valid ? residue_mem[rd_row][rd_col] : '0;
  assign out_row     = out_valid ? ROW_W'(rd_row) : '0;
  assign out_col     = out_valid ? ROW_W'(rd_col) : '0;
  assign out_ts      = ts;

`ifdef SPIKE_RESULT_ACC_REFCHK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch_cnt <= '0;
    end else if (rd_fire && (ref_spike != out_spike) && (mismatch_cnt != '1)) begin
      mismatch_cnt <= mismatch_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spike_result_acc.sv
// Self-checking bench for spike_result_acc (DEPTH_R=3, THRE=64, NUM_TS=2) against a neuron-level model.
module tb_spike_result_acc;
  localparam int DR  = 3;
  localparam int TH  = 64;
  localparam int NTS = 2;
  localparam int MAXV = 8191;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pkt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_spike;
  logic [12:0] out_residue;
  logic [4:0]  out_row, out_col;
  logic [1:0]  out_ts;
  logic        frame_done;
  logic        err_row;
`ifdef SPIKE_RESULT_ACC_REFCHK_EN
  logic        ref_spike = 1'b0;
  logic [15:0] mismatch_cnt;
`endif

  spike_result_acc #(.DEPTH_R(DR), .THRE(TH), .NUM_TS(NTS)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
    .out_valid(out_valid), .out_ready(out_ready), .out_spike(out_spike),
    .out_residue(out_residue), .out_row(out_row), .out_col(out_col),
    .out_ts(out_ts), .frame_done(frame_done), .err_row(err_row)
`ifdef SPIKE_RESULT_ACC_REFCHK_EN
    , .ref_spike(ref_spike), .mismatch_cnt(mismatch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: neuron state as plain integers.
  int m_res [DR][DR];
  bit m_spk [DR][DR];
  int m_col [DR];
  int m_pkt = 0;
  int m_ts  = 0;
  bit m_err = 0;
  bit m_read = 0;
  int cap_res [DR*DR];
  bit cap_spk [DR*DR];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pkt = 0; m_ts = 0; m_err = 0; m_read = 0;
    foreach (m_col[i]) m_col[i] = 0;
  endtask

  task automatic model_accept(input int r, input int d);
    int c, s;
    if (r >= DR) begin m_err = 1; return; end
    if (m_col[r] == DR) begin m_err = 1; return; end
    c = m_col[r];
    s = ((m_ts == 0) ? 0 : m_res[r][c]) + d;
    if (s > TH) begin m_spk[r][c] = 1; s = s - TH; end
    else m_spk[r][c] = 0;
    if (s > MAXV) s = MAXV;
    m_res[r][c] = s;
    m_col[r]++;
    m_pkt++;
    if (m_pkt == DR*DR) begin
      m_read = 1; m_pkt = 0;
      foreach (m_col[i]) m_col[i] = 0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input int r, input int d);
    int waitc;
    waitc = 0;
    in_pkt = (32'(r) << 16) | 32'(d);
    in_valid = 1'b1;
    while (!in_ready && waitc < 50) begin @(negedge clk); waitc++; end
    check("send_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    model_accept(r, d);
    check("in_ready_after_pkt", in_ready, m_read ? 0 : 1);
    check("err_row", err_row, m_err);
  endtask

  task automatic read_frame(input bit toggle, input int flip_a, input int flip_b);
    int w, r, c;
    check("read_in_ready_low", in_ready, 0);
    check("read_valid_lat0", out_valid, 0);
    @(negedge clk);
    check("read_valid_lat1", out_valid, 1);
    for (int k = 0; k < DR*DR; k++) begin
      w = 0; r = k / DR; c = k % DR;
      while (!out_valid && w < 50) begin @(negedge clk); w++; end
      check("entry_valid", out_valid, 1);
      check("entry_row", out_row, r);
      check("entry_col", out_col, c);
      check("entry_spike", out_spike, m_spk[r][c]);
      check("entry_residue", out_residue, m_res[r][c]);
      check("entry_ts", out_ts, m_ts);
      cap_res[k] = out_residue;
      cap_spk[k] = out_spike;
`ifdef SPIKE_RESULT_ACC_REFCHK_EN
      ref_spike = m_spk[r][c] ^ ((k == flip_a) || (k == flip_b));
`endif
      if (toggle) begin
        out_ready = 1'b0;
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_row", out_row, r);
        check("hold_col", out_col, c);
        check("hold_residue", out_residue, m_res[r][c]);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    check("end_in_ready", in_ready, 1);
    check("end_valid_low", out_valid, 0);
    check("frame_done", frame_done, (m_ts == NTS-1) ? 1 : 0);
    m_ts = (m_ts == NTS-1) ? 0 : m_ts + 1;
    m_read = 0;
    @(negedge clk);
    check("frame_done_pulse", frame_done, 0);
    check("next_ts", out_ts, m_ts);
  endtask

  task automatic random_frame(input bit gaps, input bit drops);
    int rows [DR*DR];
    int j, t;
    for (int k = 0; k < DR*DR; k++) rows[k] = k / DR;
    for (int k = DR*DR-1; k > 0; k--) begin
      j = int'($urandom_range(0, k));
      t = rows[k]; rows[k] = rows[j]; rows[j] = t;
    end
    for (int k = 0; k < DR*DR; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
      if (drops && $urandom_range(0, 5) == 0) send(int'($urandom_range(DR, 31)), int'($urandom_range(0, MAXV)));
      send(rows[k], int'($urandom_range(0, MAXV)));
    end
  endtask

  int b_rows [9] = '{0,0,0,1,1,1,2,2,2};
  int b_data [9] = '{10,64,65,100,0,8191,1,2,3};
  int e_res  [9] = '{10,64,1,36,0,8127,1,2,3};
  bit e_spk  [9] = '{0,0,1,1,0,1,0,0,0};
  int il_rows [9] = '{2,0,1,2,0,1,2,0,1};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_row", err_row, 0);
    check("rst_out_ts", out_ts, 0);
    check("rst_residue", out_residue, 0);
    check("rst_spike", out_spike, 0);
`ifdef SPIKE_RESULT_ACC_REFCHK_EN
    check("rst_mismatch", mismatch_cnt, 0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Basic timestep 0
    for (int k = 0; k < 9; k++) send(b_rows[k], b_data[k]);
    read_frame(0, -1, -1);
    for (int k = 0; k < 9; k++) begin
      check("basic_residue", cap_res[k], e_res[k]);
      check("basic_spike", cap_spk[k], e_spk[k]);
    end

    // Accumulation over timestep 1
    for (int k = 0; k < 9; k++) send(b_rows[k], 60);
    read_frame(0, -1, -1);
    check("acc_00_res", cap_res[0], 6);
    check("acc_00_spk", cap_spk[0], 1);
    check("acc_12_res", cap_res[5], 8123);
    check("acc_12_spk", cap_spk[5], 1);

    // Interleaved rows
    for (int k = 0; k < 9; k++) send(il_rows[k], int'($urandom_range(0, MAXV)));
    read_frame(0, -1, -1);

    // Dropped packets
    send(0, 11); send(0, 12);
    send(3, 5);
    send(0, 13); send(0, 14);
    check("err_row_set", err_row, 1);
    send(1, 70); send(1, 1); send(1, 200);
    send(2, 64); send(2, 65);
    check("still_accum_after_8", in_ready, 1);
    send(2, 8000);
    read_frame(0, -1, -1);

    // Backpressure
    random_frame(1, 0);
    read_frame(1, -1, -1);

    // Reset in the middle of READ
    random_frame(0, 0);
    check("mid_lat0", out_valid, 0);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
    check("mid_reading", out_valid, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_err", err_row, 0);
    check("mid_rst_ts", out_ts, 0);
    check("mid_rst_done", frame_done, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("post_rst_done", frame_done, 0);
    check("post_rst_in_ready", in_ready, 1);
    random_frame(0, 0);
    read_frame(0, -1, -1);

`ifdef SPIKE_RESULT_ACC_REFCHK_EN
    check("refchk_zero", mismatch_cnt, 0);
    random_frame(0, 0);
    read_frame(0, 2, 6);
    check("refchk_two", mismatch_cnt, 2);
`endif

    // Randomized frames with gaps and dropped packets
    for (int f = 0; f < 4; f++) begin
      random_frame(1, 1);
      read_frame(f[0], -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
